// File: rtl/hack_data_memory.sv
// Hack data memory and memory-mapped I/O: RAM, screen framebuffer, keyboard and LED registers,
// plus a registered framebuffer read port for the display scan-out.
module hack_data_memory #(
  parameter int          RAM_WORDS    = 16384,
  parameter logic [15:0] SCREEN_BASE  = 16'h4000,
  parameter int          SCREEN_WORDS = 8192,
  parameter logic [15:0] KBD_ADDR     = 16'h6000,
  parameter logic [15:0] LED_ADDR     = 16'h6001
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        writeM,
  input  logic [15:0] addressMW,
  input  logic [15:0] outM,
  input  logic [15:0] addressMR,
  output logic [15:0] inM,
  input  logic [12:0] scr_addr,
  output logic [15:0] scr_data,
  input  logic        kbd_valid,
  input  logic [15:0] kbd_code,
  input  logic        kbd_release,
  output logic [15:0] leds
);

  localparam int          RAM_AW  = $clog2(RAM_WORDS);
  localparam int          SCR_AW  = $clog2(SCREEN_WORDS);
  // 17-bit bounds so SCREEN_BASE + SCREEN_WORDS cannot wrap.
  localparam logic [16:0] RAM_END = 17'(RAM_WORDS);
  localparam logic [16:0] SCR_LO  = {1'b0, SCREEN_BASE};
  localparam logic [16:0] SCR_HI  = {1'b0, SCREEN_BASE} + 17'(SCREEN_WORDS);

  logic [15:0] ram [RAM_WORDS];
  logic [15:0] fb  [SCREEN_WORDS];
  logic [15:0] key_reg;
  logic [15:0] leds_reg;
  logic [15:0] scr_data_reg;

  function automatic logic is_ram(input logic [15:0] a);
    return {1'b0, a} < RAM_END;
  endfunction

  function automatic logic is_scr(input logic [15:0] a);
    return ({1'b0, a} >= SCR_LO) && ({1'b0, a} < SCR_HI);
  endfunction

  logic wr_ram, wr_scr, wr_kbd, wr_led;
  assign wr_ram = writeM && is_ram(addressMW);
  assign wr_scr = writeM && is_scr(addressMW);
  assign wr_kbd = writeM && (addressMW == KBD_ADDR);
  assign wr_led = writeM && (addressMW == LED_ADDR);

  logic scr_in_range;
  assign scr_in_range = 32'(scr_addr) < SCREEN_WORDS;

  // Storage writes are not gated by reset: contents survive, and a reset-cycle write still lands.
  always_ff @(posedge clk) begin
    if (wr_ram) ram[RAM_AW'(addressMW)] <= outM;
  end

  always_ff @(posedge clk) begin
    if (wr_scr) fb[SCR_AW'(addressMW - SCREEN_BASE)] <= outM;
  end

  // Scan-out read samples the pre-write contents, giving read-before-write on a collision.
  always_ff @(posedge clk) begin
    if (rstn) begin
      scr_data_reg <= '0;
    end else if (scr_in_range) begin
      scr_data_reg <= fb[SCR_AW'(scr_addr)];
    end else begin
      scr_data_reg <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      key_reg <= '0;
    end else if (kbd_valid) begin
      key_reg <= kbd_code;
    end else if (kbd_release || wr_kbd) begin
      key_reg <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      leds_reg <= '0;
    end else if (wr_led) begin
      leds_reg <= outM;
    end
  end

  // Zero-latency CPU read: the CPU consumes inM in the same cycle it presents addressMR.
  always_comb begin
    inM = '0;
    if (is_ram(addressMR)) begin
      inM = ram[RAM_AW'(addressMR)];
    end else if (is_scr(addressMR)) begin
      inM = fb[SCR_AW'(addressMR - SCREEN_BASE)];
    end else if (addressMR == KBD_ADDR) begin
      inM = key_reg;
    end else if (addressMR == LED_ADDR) begin
      inM = leds_reg;
    end
  end

  assign scr_data = scr_data_reg;
  assign leds     = leds_reg;

endmodule

// File: tb/tb_hack_data_memory.sv
// Directed bench for hack_data_memory: stimulus queues expected values per cycle,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_hack_data_memory;

  logic        clk = 1'b0;
  logic        rstn;
  logic        writeM;
  logic [15:0] addressMW;
  logic [15:0] outM;
  logic [15:0] addressMR;
  logic [15:0] inM;
  logic [12:0] scr_addr;
  logic [15:0] scr_data;
  logic        kbd_valid;
  logic [15:0] kbd_code;
  logic        kbd_release;
  logic [15:0] leds;

  hack_data_memory dut (
    .clk        (clk),
    .rstn       (rstn),
    .writeM     (writeM),
    .addressMW  (addressMW),
    .outM       (outM),
    .addressMR  (addressMR),
    .inM        (inM),
    .scr_addr   (scr_addr),
    .scr_data   (scr_data),
    .kbd_valid  (kbd_valid),
    .kbd_code   (kbd_code),
    .kbd_release(kbd_release),
    .leds       (leds)
  );

  always #5 clk = ~clk;

  localparam int SEL_INM  = 0;
  localparam int SEL_SCR  = 1;
  localparam int SEL_LEDS = 2;

  typedef struct {
    int          cyc;
    int          sel;
    logic [15:0] exp;
    string       name;
  } sb_t;

  sb_t q[$];
  int  cyc = 0;
  int  checks = 0;
  int  errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compares every expectation scheduled for the current cycle at mid-cycle.
  always @(negedge clk) begin
    sb_t         e;
    logic [15:0] act;
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      checks++;
      case (e.sel)
        SEL_INM: act = inM;
        SEL_SCR: act = scr_data;
        default: act = leds;
      endcase
      if (e.cyc != cyc || act !== e.exp) begin
        errors++;
        $display("FAIL %s: got %h expected %h (cycle %0d, scheduled %0d)", e.name, act, e.exp, cyc, e.cyc);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_now(input int sel, input logic [15:0] v, input string nm);
    q.push_back('{cyc, sel, v, nm});
  endtask

  task automatic cyc_write(input logic [15:0] a, input logic [15:0] d);
    writeM = 1'b1; addressMW = a; outM = d;
    step();
    writeM = 1'b0;
  endtask

  task automatic read_check(input logic [15:0] a, input logic [15:0] v, input string nm);
    addressMR = a;
    expect_now(SEL_INM, v, nm);
    $display("read  addr=%h expect=%h (%s)", a, v, nm);
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b1; writeM = 1'b0; addressMW = '0; outM = '0; addressMR = '0;
    scr_addr = '0; kbd_valid = 1'b0; kbd_code = '0; kbd_release = 1'b0;
    step(); step();
    rstn = 1'b0;
    addressMR = 16'h6000;
    expect_now(SEL_LEDS, 16'h0000, "reset_leds");
    expect_now(SEL_SCR, 16'h0000, "reset_scr_data");
    expect_now(SEL_INM, 16'h0000, "reset_key");
    $display("reset released, checking reset state");
    step();

    // RAM write then read, and no forwarding in the write cycle
    cyc_write(16'h0005, 16'h1111);
    addressMR = 16'h0005;
    writeM = 1'b1; addressMW = 16'h0005; outM = 16'h1234;
    expect_now(SEL_INM, 16'h1111, "ram_old_in_write_cycle");
    $display("write addr=0005 data=1234, same-cycle read expects old 1111");
    step();
    writeM = 1'b0;
    expect_now(SEL_INM, 16'h1234, "ram_read_after_write");
    step();

    // Framebuffer via CPU and scan-out port
    cyc_write(16'h4000, 16'hFFFF);
    cyc_write(16'h5FFF, 16'h00F0);
    scr_addr = 13'd0;
    step();
    expect_now(SEL_SCR, 16'hFFFF, "scr_word0");
    scr_addr = 13'd8191;
    step();
    expect_now(SEL_SCR, 16'h00F0, "scr_word8191");
    addressMR = 16'h4000;
    expect_now(SEL_INM, 16'hFFFF, "cpu_read_screen");
    $display("scan-out words 0 and 8191, CPU read of 4000");
    step();
    scr_addr = 13'd0;
    cyc_write(16'h4000, 16'h1357);
    expect_now(SEL_SCR, 16'hFFFF, "scr_read_before_write");
    step();
    expect_now(SEL_SCR, 16'h1357, "scr_after_write");
    $display("scan-out collision on word 0: old then new");
    step();

    // Keyboard register priority
    addressMR = 16'h6000;
    kbd_valid = 1'b1; kbd_code = 16'd65;
    step();
    kbd_valid = 1'b0;
    expect_now(SEL_INM, 16'd65, "kbd_code65");
    kbd_release = 1'b1;
    step();
    kbd_release = 1'b0;
    expect_now(SEL_INM, 16'd0, "kbd_release");
    kbd_valid = 1'b1; kbd_code = 16'd66;
    step();
    kbd_valid = 1'b0;
    expect_now(SEL_INM, 16'd66, "kbd_code66");
    cyc_write(16'h6000, 16'h5555);
    expect_now(SEL_INM, 16'd0, "kbd_write_clear");
    kbd_valid = 1'b1; kbd_code = 16'd67;
    writeM = 1'b1; addressMW = 16'h6000; outM = 16'h5555;
    step();
    kbd_valid = 1'b0; writeM = 1'b0;
    expect_now(SEL_INM, 16'd67, "kbd_valid_beats_write");
    kbd_valid = 1'b1; kbd_release = 1'b1; kbd_code = 16'd68;
    step();
    kbd_valid = 1'b0; kbd_release = 1'b0;
    expect_now(SEL_INM, 16'd68, "kbd_valid_beats_release");
    $display("keyboard sequence 65/0/66/0/67/68");
    step();

    // LED register and reset behaviour
    cyc_write(16'h6001, 16'hA5A5);
    addressMR = 16'h6001;
    expect_now(SEL_LEDS, 16'hA5A5, "leds_write");
    expect_now(SEL_INM, 16'hA5A5, "leds_readback");
    $display("write addr=6001 data=A5A5");
    step();
    rstn = 1'b1;
    writeM = 1'b1; addressMW = 16'h6001; outM = 16'h9999;
    step();
    expect_now(SEL_LEDS, 16'h0000, "reset_overrides_led_write");
    addressMW = 16'h0007; outM = 16'h7777;
    step();
    rstn = 1'b0; writeM = 1'b0;
    addressMR = 16'h6000;
    expect_now(SEL_LEDS, 16'h0000, "mid_reset_leds");
    expect_now(SEL_INM, 16'h0000, "mid_reset_key");
    expect_now(SEL_SCR, 16'h0000, "mid_reset_scr_data");
    $display("mid-operation reset with RAM write in reset cycle");
    step();
    read_check(16'h0005, 16'h1234, "ram_survives_reset");
    read_check(16'h0007, 16'h7777, "ram_write_during_reset");

    // Unmapped writes are ignored
    cyc_write(16'h0002, 16'h2222);
    cyc_write(16'h3FFF, 16'h3FFF);
    cyc_write(16'h6001, 16'h00C3);
    kbd_valid = 1'b1; kbd_code = 16'h0045;
    step();
    kbd_valid = 1'b0;
    cyc_write(16'h6002, 16'hBEEF);
    cyc_write(16'h7FFF, 16'hBEEF);
    expect_now(SEL_LEDS, 16'h00C3, "unmapped_leds_unchanged");
    read_check(16'h6002, 16'h0000, "unmapped_6002");
    read_check(16'h7FFF, 16'h0000, "unmapped_7FFF");
    read_check(16'h0002, 16'h2222, "unmapped_ram_0002");
    read_check(16'h3FFF, 16'h3FFF, "unmapped_ram_3FFF");
    read_check(16'h4000, 16'h1357, "unmapped_scr_4000");
    read_check(16'h5FFF, 16'h00F0, "unmapped_scr_5FFF");
    read_check(16'h6000, 16'h0045, "unmapped_key");

    // Back-to-back writes then sequential readback
    for (int i = 0; i < 16; i++) begin
      writeM = 1'b1; addressMW = 16'(i); outM = 16'(i * 3);
      step();
    end
    writeM = 1'b0;
    for (int i = 0; i < 16; i++) begin
      read_check(16'(i), 16'(i * 3), $sformatf("b2b_word%0d", i));
    end

    step(); step();
    if (q.size() != 0) begin
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
      errors += q.size();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hack_data_memory.md
Name: hack_data_memory

Overview:
Data-memory and memory-mapped I/O stage directly downstream of the Hack CPU. It consumes the CPU's write strobe, write address and write data, and returns read data for the CPU's read address. It decodes the Hack address map into RAM, screen framebuffer, keyboard register and an LED register. It also provides a synchronous read port that the display scan-out logic uses to fetch framebuffer words.

Parameters:
RAM_WORDS, 16384, number of general RAM words; decoded at 0x0000..RAM_WORDS-1.
SCREEN_BASE, 16'h4000, first framebuffer address.
SCREEN_WORDS, 8192, number of framebuffer words.
KBD_ADDR, 16'h6000, keyboard register address.
LED_ADDR, 16'h6001, LED register address.

Ports:
clk  in  1  single system clock; all state changes on its rising edge.
rstn  in  1  reset; synchronous, active-high (1 = reset), sampled on rising clk.
writeM  in  1  CPU write strobe.
addressMW  in  16  CPU write address.
outM  in  16  CPU write data.
addressMR  in  16  CPU read address.
inM  out  16  read data to CPU (combinational from addressMR).
scr_addr  in  13  scan-out framebuffer word index (0..SCREEN_WORDS-1).
scr_data  out  16  scan-out read data, registered.
kbd_valid  in  1  one-cycle pulse: new key code present on kbd_code.
kbd_code  in  16  key code from keyboard decoder.
kbd_release  in  1  one-cycle pulse: key released.
leds  out  16  LED register contents.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rstn, 1 = reset).
- Address decode applies to both addressMR and addressMW:
  - RAM: address < RAM_WORDS.
  - SCREEN: SCREEN_BASE <= address < SCREEN_BASE+SCREEN_WORDS.
  - KBD: address == KBD_ADDR.
  - LED: address == LED_ADDR.
  - Any other address is unmapped.
- CPU read path: inM is a combinational function of addressMR and current storage, with zero latency. The CPU samples inM in the same cycle addressMR changes, so a registered RAM read is not permitted on this port.
  - RAM/SCREEN: return the stored word.
  - KBD: return the key register.
  - LED: return the leds register.
  - Unmapped: return 16'h0000.
- CPU write path: on a rising clk with writeM=1, write outM to the word decoded from addressMW.
  - KBD write: clears the key register to 0; the data value is ignored (write-to-clear).
  - LED write: loads leds.
  - Unmapped write: ignored, with no side effects.
  - writeM=0: no storage change.
- Read-after-write: a write committed at edge N is visible on inM from the cycle after edge N. In the same cycle as the write, inM shows the old value (no write-through forwarding).
- Scan-out port: scr_data <= framebuffer[scr_addr] every cycle, with 1-cycle latency.
  - If the CPU writes the same word at the same edge, scr_data returns the old value (read-before-write).
  - scr_addr >= SCREEN_WORDS returns 0.
- Key register (16 bit), updated each clock edge with this priority, highest first:
  1. rstn → 0.
  2. kbd_valid → kbd_code.
  3. kbd_release → 0.
  4. CPU write to KBD_ADDR → 0.
  5. Otherwise hold.
  - kbd_valid together with a CPU KBD write in the same cycle: the new code wins.
- Reset values:
  - Key register = 0, leds = 0, scr_data = 0.
  - RAM and framebuffer contents are not cleared by reset.
  - inM reflects the reset key/led values immediately after the reset edge.
- Reset mid-operation: a write with writeM=1 in the reset cycle is still performed to RAM/SCREEN. Writes to LED/KBD in that cycle are overridden by reset.
- No internal state machine beyond the registers above. The block must accept a write every cycle and a read every cycle with no stall or handshake back to the CPU.

Test Plan:
- Write 16'h1234 to addr 0x0005 (writeM pulse), then set addressMR=0x0005 → inM=16'h1234 in the next cycle. In the write cycle itself, with addressMR=0x0005, inM shows the prior value.
- Write 16'hFFFF to 0x4000 and 16'h00F0 to 0x5FFF; drive scr_addr=0, then scr_addr=8191 → scr_data=16'hFFFF and 16'h00F0, each one cycle after the address. addressMR=0x4000 gives inM=16'hFFFF combinationally.
- Pulse kbd_valid with kbd_code=16'd65 → inM@0x6000=65 the next cycle. Pulse kbd_release → 0. Repeat with code 66, then CPU writes 16'h5555 to 0x6000 → reads 0. kbd_valid (code 67) in the same cycle as a CPU KBD write → reads 67.
- Write 16'hA5A5 to 0x6001 → leds=16'hA5A5 after the edge and inM@0x6001=16'hA5A5. Assert rstn for one cycle → leds=0, key=0, and RAM word 0x0005 still holds 16'h1234.
- Write 16'hBEEF to 0x6002 and 0x7FFF → reads at both addresses return 0. RAM words 0x0002 and 0x3FFF, the framebuffer, leds and key register are all unchanged.
- Back-to-back writes every cycle to 0x0000..0x000F with data=addr*3, then read back sequentially → every word matches, with no dropped writes.
